// File: rtl/auth_pkg.sv
// auth_pkg: protocol codes, completion status encodings and FSM states
// shared by the authentication initiator controller and its timer.
package auth_pkg;
   localparam logic [7:0] PROTO_VER       = 8'h01;
   localparam logic [7:0] REQ_GET_DIGESTS = 8'h81;
   localparam logic [7:0] REQ_GET_CERT    = 8'h82;
   localparam logic [7:0] REQ_CHALLENGE   = 8'h83;
   localparam logic [7:0] RSP_DIGESTS     = 8'h01;
   localparam logic [7:0] RSP_CERT        = 8'h02;
   localparam logic [7:0] RSP_CHALLENGE   = 8'h03;
   localparam logic [7:0] RSP_ERROR       = 8'h7F;
   localparam logic [7:0] ERR_INVALID_REQ = 8'h01;
   localparam logic [7:0] ERR_UNSUPPORTED = 8'h02;
   localparam logic [7:0] ERR_BUSY        = 8'h03;
   localparam logic [7:0] ERR_UNSPECIFIED = 8'h04;
   localparam logic [1:0] TYPE_DIGESTS    = 2'd0;
   localparam logic [1:0] TYPE_CERT       = 2'd1;
   localparam logic [1:0] TYPE_CHAL       = 2'd2;
   localparam logic [1:0] TYPE_ILLEGAL    = 2'd3;
   localparam logic [2:0] DS_OK           = 3'd0;
   localparam logic [2:0] DS_TIMEOUT      = 3'd1;
   localparam logic [2:0] DS_BUSY         = 3'd2;
   localparam logic [2:0] DS_INVALID_RSP  = 3'd3;
   localparam logic [2:0] DS_UNSPECIFIED  = 3'd4;
   localparam logic [2:0] DS_ILLEGAL_REQ  = 3'd5;
   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_SEND = 4'b0010,
      S_WAIT = 4'b0100,
      S_DONE = 4'b1000
   } state_t;
   function automatic logic [7:0] req_code(input logic [1:0] t);
      return t == TYPE_CHAL ? REQ_CHALLENGE : t == TYPE_CERT ? REQ_GET_CERT : REQ_GET_DIGESTS;
   endfunction
   function automatic logic [7:0] rsp_code(input logic [1:0] t);
      return t == TYPE_CHAL ? RSP_CHALLENGE : t == TYPE_CERT ? RSP_CERT : RSP_DIGESTS;
   endfunction
endpackage

// File: rtl/auth_ms_timer.sv
// auth_ms_timer: millisecond prescaler and counter; expired pulses on the
// cycle whose wrap would bring the ms count up to the selected timeout.
module auth_ms_timer
   import auth_pkg::*;
#(
   parameter int CLK_PER_MS   = 1000,
   parameter int T_DIGESTS_MS = 200,
   parameter int T_CERT_MS    = 200,
   parameter int T_CHAL_MS    = 1200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic [1:0] sel,
   output logic       expired
);
   localparam int T_MAX = (T_CHAL_MS > T_CERT_MS) ?
                          ((T_CHAL_MS > T_DIGESTS_MS) ? T_CHAL_MS : T_DIGESTS_MS) :
                          ((T_CERT_MS > T_DIGESTS_MS) ? T_CERT_MS : T_DIGESTS_MS);
   localparam int PW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
   localparam int MW = $clog2(T_MAX + 1);
   logic [PW-1:0] presc;
   logic [MW-1:0] ms_cnt;
   logic [MW-1:0] t_sel;
   logic          wrap;
   always_comb begin
      t_sel   = sel == TYPE_CHAL ? MW'(T_CHAL_MS) : sel == TYPE_CERT ? MW'(T_CERT_MS) : MW'(T_DIGESTS_MS);
      wrap    = presc == PW'(CLK_PER_MS - 1);
      expired = !clear && wrap && ms_cnt == t_sel - 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         presc  <= '0;
         ms_cnt <= '0;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) ms_cnt <= ms_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/auth_initiator_ctrl.sv
// auth_initiator_ctrl: issues one authentication request at a time, waits for
// the reply under a per-request timeout and retries on Busy or timeout.
module auth_initiator_ctrl
   import auth_pkg::*;
#(
   parameter int MSG_W        = 1000,
   parameter int CLK_PER_MS   = 1000,
   parameter int T_DIGESTS_MS = 200,
   parameter int T_CERT_MS    = 200,
   parameter int T_CHAL_MS    = 1200,
   parameter int MAX_RETRY    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [1:0]       req_type,
   input  logic [MSG_W-1:0] req_payload,
   output logic             req_ready,
   output logic             tx_valid,
   output logic [MSG_W-1:0] tx_msg,
   input  logic             tx_ready,
   input  logic             rx_valid,
   input  logic [MSG_W-1:0] rx_msg,
   output logic             done_valid,
   output logic [2:0]       done_status,
   output logic [MSG_W-1:0] done_msg
);
   localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
   state_t        state;
   logic [1:0]    typ;
   logic [RW-1:0] retry_cnt;
   logic          expired;
   logic [7:0]    rsp_type;
   logic [7:0]    rsp_p1;
   logic          is_err;
   logic          busy;
   logic          resend;
   logic [2:0]    outcome;
   auth_ms_timer #(
      .CLK_PER_MS  (CLK_PER_MS),
      .T_DIGESTS_MS(T_DIGESTS_MS),
      .T_CERT_MS   (T_CERT_MS),
      .T_CHAL_MS   (T_CHAL_MS)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != S_WAIT),
      .sel    (typ),
      .expired(expired)
   );
   // A response on the timeout cycle takes priority over the timeout.
   always_comb begin
      rsp_type = rx_msg[15:8];
      rsp_p1   = rx_msg[23:16];
      is_err   = rsp_type == RSP_ERROR;
      busy     = is_err && rsp_p1 == ERR_BUSY;
      resend   = (rx_valid ? busy : expired) && retry_cnt < RW'(MAX_RETRY);
      outcome  = !rx_valid ? DS_TIMEOUT :
                 rsp_type == rsp_code(typ) ? DS_OK :
                 busy ? DS_BUSY :
                 is_err && (rsp_p1 == ERR_INVALID_REQ || rsp_p1 == ERR_UNSUPPORTED) ? DS_INVALID_RSP :
                 is_err ? DS_UNSPECIFIED : DS_INVALID_RSP;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         typ         <= TYPE_DIGESTS;
         retry_cnt   <= '0;
         req_ready   <= 1'b0;
         tx_valid    <= 1'b0;
         tx_msg      <= '0;
         done_valid  <= 1'b0;
         done_status <= DS_OK;
         done_msg    <= '0;
      end else begin
         done_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  if (req_type == TYPE_ILLEGAL) begin
                     state       <= S_DONE;
                     done_valid  <= 1'b1;
                     done_status <= DS_ILLEGAL_REQ;
                     done_msg    <= '0;
                  end else begin
                     typ          <= req_type;
                     tx_msg       <= req_payload;
                     tx_msg[15:0] <= {req_code(req_type), PROTO_VER};
                     retry_cnt    <= '0;
                     tx_valid     <= 1'b1;
                     state        <= S_SEND;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rx_valid || expired) begin
                  if (resend) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     tx_valid  <= 1'b1;
                     state     <= S_SEND;
                  end else begin
                     state       <= S_DONE;
                     done_valid  <= 1'b1;
                     done_status <= outcome;
                     done_msg    <= rx_valid ? rx_msg : '0;
                  end
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_auth_initiator_ctrl.sv
// tb_auth_initiator_ctrl: directed and randomized checks of the initiator
// against a cycle-counting reference model of the request/response rules.
module tb_auth_initiator_ctrl;
   localparam int MSG_W = 64;
   localparam int CPM   = 4;
   localparam int T_DIG = 2;
   localparam int T_CRT = 3;
   localparam int T_CHL = 5;
   localparam int MAXR  = 1;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic [1:0]       req_type = 2'd0;
   logic [MSG_W-1:0] req_payload = '0;
   logic             req_ready;
   logic             tx_valid;
   logic [MSG_W-1:0] tx_msg;
   logic             tx_ready = 1'b1;
   logic             rx_valid = 1'b0;
   logic [MSG_W-1:0] rx_msg = '0;
   logic             done_valid;
   logic [2:0]       done_status;
   logic [MSG_W-1:0] done_msg;
   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 0;
   auth_initiator_ctrl #(
      .MSG_W(MSG_W), .CLK_PER_MS(CPM), .T_DIGESTS_MS(T_DIG),
      .T_CERT_MS(T_CRT), .T_CHAL_MS(T_CHL), .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
      .req_payload(req_payload), .req_ready(req_ready), .tx_valid(tx_valid),
      .tx_msg(tx_msg), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_msg(rx_msg),
      .done_valid(done_valid), .done_status(done_status), .done_msg(done_msg)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [MSG_W-1:0] got, input logic [MSG_W-1:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask
   // Reference model: outcome rules and deadlines counted in clock edges.
   function automatic logic [2:0] classify(input logic [1:0] t, input logic [MSG_W-1:0] r);
      logic [7:0] ty, p;
      ty = r[15:8];
      p  = r[23:16];
      if (ty == 8'h01 + 8'(t)) return 3'd0;
      if (ty != 8'h7F) return 3'd3;
      if (p == 8'h03) return 3'd2;
      if (p == 8'h01 || p == 8'h02) return 3'd3;
      return 3'd4;
   endfunction
   function automatic int tmo_cycles(input logic [1:0] t);
      return (t == 2'd2 ? T_CHL : t == 2'd1 ? T_CRT : T_DIG) * CPM;
   endfunction
   logic             e_ready, e_txv, e_dv;
   logic [MSG_W-1:0] e_txmsg, e_msg;
   logic [2:0]       e_st, m_st;
   logic             m_wait = 1'b0;
   logic [1:0]       m_type = 2'd0;
   int               m_tries = 0;
   int               m_deadline = 0;
   int               cyc = 0;
   int               hs = 0;
   always_comb m_st = rx_valid ? classify(m_type, rx_msg) : 3'd1;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && tx_valid && tx_ready) hs <= hs + 1;
      if (reset) begin
         e_ready <= 1'b0; e_txv <= 1'b0; e_dv <= 1'b0; e_st <= 3'd0;
         e_txmsg <= '0; e_msg <= '0; m_wait <= 1'b0;
      end else if (e_dv) begin
         e_dv <= 1'b0; e_ready <= 1'b1;
      end else if (e_ready) begin
         if (req_valid) begin
            e_ready <= 1'b0;
            if (req_type == 2'd3) begin
               e_dv <= 1'b1; e_st <= 3'd5; e_msg <= '0;
            end else begin
               m_type  <= req_type;
               e_txmsg <= {req_payload[MSG_W-1:16], 8'h81 + 8'(req_type), 8'h01};
               e_txv   <= 1'b1;
               m_tries <= 0;
            end
         end
      end else if (e_txv) begin
         if (tx_ready) begin
            e_txv <= 1'b0; m_wait <= 1'b1; m_deadline <= cyc + tmo_cycles(m_type);
         end
      end else if (m_wait) begin
         if (rx_valid || cyc == m_deadline) begin
            m_wait <= 1'b0;
            if ((m_st == 3'd2 || m_st == 3'd1) && m_tries < MAXR) begin
               e_txv <= 1'b1; m_tries <= m_tries + 1;
            end else begin
               e_dv <= 1'b1; e_st <= m_st; e_msg <= rx_valid ? rx_msg : '0;
            end
         end
      end else begin
         e_ready <= 1'b1;
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", MSG_W'(req_ready), MSG_W'(e_ready));
         check("tx_valid", MSG_W'(tx_valid), MSG_W'(e_txv));
         check("tx_msg", tx_msg, e_txmsg);
         check("done_valid", MSG_W'(done_valid), MSG_W'(e_dv));
         check("done_status", MSG_W'(done_status), MSG_W'(e_st));
         check("done_msg", done_msg, e_msg);
      end
   end
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic send_req(input logic [1:0] t, input logic [MSG_W-1:0] p);
      int k = 0;
      while (!req_ready && k < 100) begin tick(); k++; end
      check("req_ready_wait", MSG_W'(req_ready), 1);
      req_valid = 1'b1; req_type = t; req_payload = p;
      tick();
      req_valid = 1'b0;
   endtask
   task automatic reply_after(input int d, input logic [MSG_W-1:0] m);
      int k = 0;
      while (!m_wait && k < 100) begin tick(); k++; end
      check("handshake_wait", MSG_W'(m_wait), 1);
      repeat (d - 1) tick();
      rx_valid = 1'b1; rx_msg = m;
      tick();
      rx_valid = 1'b0;
   endtask
   task automatic wait_done(output logic [2:0] st, output logic [MSG_W-1:0] m);
      int k = 0;
      while (!done_valid && k < 100) begin tick(); k++; end
      check("done_wait", MSG_W'(done_valid), 1);
      st = done_status; m = done_msg;
   endtask
   function automatic logic [MSG_W-1:0] mk_rsp(input logic [7:0] ty, input logic [7:0] p);
      return {40'hA5_5A3C_C301, p, ty, 8'h01};
   endfunction
   function automatic logic [MSG_W-1:0] gen_rsp(input logic [1:0] t);
      logic [MSG_W-1:0] r;
      logic [7:0] ty, p;
      r = {$urandom, $urandom};
      p = r[23:16];
      ty = r[15:8];
      case ($urandom_range(0, 4))
         0: ty = 8'h01 + 8'(t);
         1: begin ty = 8'h7F; p = 8'h03; end
         2: begin ty = 8'h7F; p = 8'($urandom_range(1, 2)); end
         3: ty = 8'h7F;
         default: ;
      endcase
      return {r[MSG_W-1:24], p, ty, 8'h01};
   endfunction
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
      $fatal(1);
   end
   initial begin
      logic [2:0] st;
      logic [MSG_W-1:0] m, p;
      int h0, k, pulses;
      reset = 1'b1;
      tick();
      chk_en = 1;
      tick();
      reset = 1'b0;
      // GET_DIGESTS answered three cycles after the handshake
      p = 64'h1122_3344_5566_7788;
      send_req(2'd0, p);
      check("hdr_digests", MSG_W'(tx_msg[15:0]), MSG_W'(16'h8101));
      check("txmsg_body", tx_msg, 64'h1122_3344_5566_8101);
      reply_after(3, mk_rsp(8'h01, 8'h00));
      check("ok_done_valid", MSG_W'(done_valid), 1);
      check("ok_status", MSG_W'(done_status), 0);
      check("ok_msg", done_msg, mk_rsp(8'h01, 8'h00));
      // no response: resend after T*CPM cycles, then TIMEOUT
      h0 = hs;
      send_req(2'd0, {$urandom, $urandom});
      k = 0;
      while (!m_wait && k < 20) begin tick(); k++; end
      k = 0;
      while (!tx_valid && k < 40) begin tick(); k++; end
      check("resend_gap", MSG_W'(k), 8);
      wait_done(st, m);
      check("tmo_status", MSG_W'(st), 1);
      check("tmo_msg", m, 0);
      check("tmo_handshakes", MSG_W'(hs - h0), 2);
      // CHALLENGE: Busy, resend, Busy again
      h0 = hs;
      send_req(2'd2, {$urandom, $urandom});
      check("hdr_chal", MSG_W'(tx_msg[15:0]), MSG_W'(16'h8301));
      reply_after(2, mk_rsp(8'h7F, 8'h03));
      reply_after(2, mk_rsp(8'h7F, 8'h03));
      wait_done(st, m);
      check("busy_status", MSG_W'(st), 2);
      check("busy_msg", m, mk_rsp(8'h7F, 8'h03));
      check("busy_handshakes", MSG_W'(hs - h0), 2);
      send_req(2'd2, {$urandom, $urandom});
      reply_after(4, mk_rsp(8'h7F, 8'h04));
      wait_done(st, m);
      check("unspec_status", MSG_W'(st), 4);
      send_req(2'd2, {$urandom, $urandom});
      reply_after(1, mk_rsp(8'h02, 8'h00));
      wait_done(st, m);
      check("wrongtype_status", MSG_W'(st), 3);
      send_req(2'd1, {$urandom, $urandom});
      reply_after(2, mk_rsp(8'h7F, 8'h01));
      wait_done(st, m);
      check("invalid_status", MSG_W'(st), 3);
      // transport stalls: no timeout while in SEND
      tx_ready = 1'b0;
      p = 64'hDEAD_BEEF_0BAD_F00D;
      send_req(2'd1, p);
      for (int i = 0; i < 20; i++) begin
         check("stall_txv", MSG_W'(tx_valid), 1);
         check("stall_txmsg", tx_msg, 64'hDEAD_BEEF_0BAD_8201);
         tick();
      end
      tx_ready = 1'b1;
      reply_after(3, mk_rsp(8'h02, 8'h00));
      wait_done(st, m);
      check("stall_status", MSG_W'(st), 0);
      // response on the timeout cycle wins
      h0 = hs;
      send_req(2'd0, {$urandom, $urandom});
      reply_after(T_DIG * CPM, mk_rsp(8'h01, 8'h00));
      check("tie_done_valid", MSG_W'(done_valid), 1);
      check("tie_status", MSG_W'(done_status), 0);
      check("tie_handshakes", MSG_W'(hs - h0), 1);
      // illegal request
      h0 = hs;
      send_req(2'd3, {$urandom, $urandom});
      wait_done(st, m);
      check("illegal_status", MSG_W'(st), 5);
      check("illegal_msg", m, 0);
      check("illegal_no_tx", MSG_W'(hs - h0), 0);
      // reset mid-WAIT
      send_req(2'd2, {$urandom, $urandom});
      k = 0;
      while (!m_wait && k < 20) begin tick(); k++; end
      tick(); tick();
      reset = 1'b1;
      tick();
      check("rst_txv", MSG_W'(tx_valid), 0);
      check("rst_dv", MSG_W'(done_valid), 0);
      check("rst_ready", MSG_W'(req_ready), 0);
      check("rst_status", MSG_W'(done_status), 0);
      reset = 1'b0;
      tick();
      check("rst_ready_after", MSG_W'(req_ready), 1);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (done_valid) pulses++;
         tick();
      end
      check("rst_no_stale_done", MSG_W'(pulses), 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         req_valid   = $urandom_range(0, 3) == 0;
         req_type    = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
         req_payload = {$urandom, $urandom};
         tx_ready    = $urandom_range(0, 3) != 0;
         rx_valid    = $urandom_range(0, 9) == 0;
         rx_msg      = gen_rsp(m_type);
         reset       = $urandom_range(0, 499) == 0;
         tick();
      end
      req_valid = 1'b0; rx_valid = 1'b0; reset = 1'b0; tx_ready = 1'b1;
      repeat (50) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/auth_initiator_ctrl.md
Name: auth_initiator_ctrl

Overview:
Parametrised authentication-initiator controller for the USB Type-C authentication driver. Accepts one request at a time: GET_DIGESTS, GET_CERTIFICATE or CHALLENGE. It builds the request header, sends the message over a valid/ready TX channel, then waits for the responder's reply under a per-request millisecond timeout. Busy errors and timeouts are retried up to a configurable limit; a completion status and the response message are returned to the policy layer.

Parameters:
MSG_W, 1000, width of request payload and TX/RX message bus (min 32)
CLK_PER_MS, 1000, clk cycles per millisecond tick (>=1)
T_DIGESTS_MS, 200, GET_DIGESTS response timeout in ms
T_CERT_MS, 200, GET_CERTIFICATE response timeout in ms
T_CHAL_MS, 1200, CHALLENGE response timeout in ms
MAX_RETRY, 2, resends allowed after timeout/Busy (0 = none)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_type  in  2  0 = GET_DIGESTS, 1 = GET_CERTIFICATE, 2 = CHALLENGE, 3 = illegal
req_payload  in  MSG_W  request body; bits [15:0] are overwritten by the header
req_ready  out  1  high only in IDLE
tx_valid  out  1  request message valid
tx_msg  out  MSG_W  request message
tx_ready  in  1  transport accepts tx_msg
rx_valid  in  1  one-cycle response strobe
rx_msg  in  MSG_W  response: [7:0] version, [15:8] type, [23:16] param1
done_valid  out  1  one-cycle completion pulse
done_status  out  3  0 OK, 1 TIMEOUT, 2 BUSY, 3 INVALID_RSP, 4 UNSPECIFIED, 5 ILLEGAL_REQ
done_msg  out  MSG_W  captured response (zero on TIMEOUT/ILLEGAL_REQ)

Behaviour:
- Reset (sync, active-high) is evaluated every clk edge and overrides everything, including mid-operation.
  - State to IDLE; all counters, tx_valid, done_valid, done_status, tx_msg and done_msg cleared.
  - req_ready goes high on the cycle after reset deasserts.
- FSM states: IDLE, SEND, WAIT, DONE. One-hot encoding.
- IDLE:
  - req_valid & req_ready with req_type 3 -> DONE, status ILLEGAL_REQ.
  - Otherwise latch the request: tx_msg = {req_payload[MSG_W-1:16], code, 8'h01}, where code = 0x81/0x82/0x83 for types 0/1/2. retry_cnt = 0. -> SEND.
- SEND:
  - tx_valid = 1. tx_msg is stable until the handshake.
  - tx_valid & tx_ready -> WAIT. tx_valid drops the next cycle. Timers cleared.
  - No timeout applies while waiting in SEND.
- WAIT timer:
  - The prescaler counts 0..CLK_PER_MS-1. On wrap, ms_cnt increments.
  - Timeout fires when ms_cnt reaches T_sel. That is exactly T_sel*CLK_PER_MS cycles after the handshake cycle.
  - T_sel is selected by the latched type.
- WAIT, on rx_valid (rx_valid outside WAIT is ignored):
  - Type equals expected (0x01/0x02/0x03 for 0x81/0x82/0x83) -> DONE, OK.
  - Type 0x7F with param1 0x03 (Busy): retry_cnt < MAX_RETRY -> retry_cnt++, SEND with the same tx_msg; else DONE, BUSY.
  - Type 0x7F with param1 0x01 or 0x02 -> DONE, INVALID_RSP.
  - Type 0x7F with any other param1 -> DONE, UNSPECIFIED.
  - Any other type -> DONE, INVALID_RSP.
- WAIT, on timeout:
  - retry_cnt < MAX_RETRY -> retry_cnt++, SEND.
  - Else DONE, TIMEOUT.
- rx_valid and timeout in the same cycle: rx_valid wins.
- DONE:
  - done_valid = 1 for exactly one cycle.
  - done_msg = rx_msg captured at the completing rx_valid.
  - Then IDLE.
  - done_status and done_msg hold until the next DONE or reset.
- Counter widths: sized with $clog2 of their maxima. No wrap is possible before timeout.

Decomposition:
- Package auth_pkg: request/response codes (0x81–0x83, 0x01–0x03, 0x7F), error codes (0x01–0x04), protocol version 0x01, done_status encodings, FSM state constants.
- Sub-module auth_ms_timer: prescaler + ms counter with clear, sel timeout value, and one-cycle expired output.

Test Plan:
- Params CLK_PER_MS=4, T_DIGESTS_MS=2, MAX_RETRY=1, tx_ready=1. Issue GET_DIGESTS; rx_valid with type 0x01 three cycles after the handshake -> tx_msg[15:0]=16'h8101, done_valid one cycle later, status 0, done_msg = rx_msg.
- GET_DIGESTS, no response -> tx resent 8 cycles after the first handshake; second timeout 8 cycles later -> status 1, done_msg = 0, exactly two TX handshakes.
- CHALLENGE, reply 0x7F/0x03 twice (MAX_RETRY=1) -> one resend, then status 2. Reply 0x7F/0x04 -> status 4. Reply type 0x02 to CHALLENGE -> status 3.
- tx_ready held low 20 cycles in SEND -> no timeout, tx_valid stays high, tx_msg stable. rx_valid in the same cycle as the timeout -> status 0, no resend.
- req_type=3 -> status 5 with no TX activity. Reset asserted mid-WAIT -> next cycle tx_valid=0, done_valid=0, req_ready=1 after deassert, no stale done pulse.
